// File: rtl/wb_pkg.sv
// wb_pkg: shared load-type encodings, writeback FSM states and link register index
package wb_pkg;
    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LH  = 3'd1;
    localparam logic [2:0] LT_LHU = 3'd2;
    localparam logic [2:0] LT_LB  = 3'd3;
    localparam logic [2:0] LT_LBU = 3'd4;
    localparam logic [4:0] LINK_REG = 5'd31;
    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;
endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: little-endian lane select and sign/zero extension of a loaded word
module wb_load_align
    import wb_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_load_type,
    output logic [31:0] o_data
);
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    always_comb begin
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
        w_byte = i_rdata[{i_addr, 3'b000} +: 8];
        o_data = (i_load_type == LT_LH)  ? {{16{w_half[15]}}, w_half} :
                 (i_load_type == LT_LHU) ? {16'h0, w_half} :
                 (i_load_type == LT_LB)  ? {{24{w_byte[7]}}, w_byte} :
                 (i_load_type == LT_LBU) ? {24'h0, w_byte} : i_rdata;
    end
endmodule

// File: rtl/wb_writeback_unit.sv
// wb_writeback_unit: drives the register-file write port from ALU, jal and load results,
// stalling upstream while a variable-latency load is outstanding.
module wb_writeback_unit
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_reg_write,
    input  logic        i_mem_to_reg,
    input  logic        i_jal,
    input  logic [4:0]  i_dest,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_link_addr,
    input  logic [2:0]  i_load_type,
    input  logic        i_mem_rdata_valid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_wb_en,
    output logic [4:0]  o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic        o_stall,
    output logic        o_load_timeout
);
    wb_state_t        r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_dest;
    logic [2:0]       r_type;
    logic [1:0]       r_addr;
    logic             r_wb_en, r_timeout;
    logic [4:0]       r_wb_addr;
    logic [31:0]      r_wb_data;
    logic             w_waiting, w_transfer, w_load, w_done, w_expire, w_wr;
    logic [4:0]       w_wr_addr;
    logic [31:0]      w_wr_data, w_aligned;

    wb_load_align u_align (
        .i_rdata     (i_mem_rdata),
        .i_addr      (r_addr),
        .i_load_type (r_type),
        .o_data      (w_aligned)
    );

    always_comb begin
        w_waiting  = (r_state == WAIT_MEM);
        w_transfer = i_valid & ~w_waiting;
        w_load     = w_transfer & i_reg_write & i_mem_to_reg & ~i_jal;
        w_done     = w_waiting & i_mem_rdata_valid;
        w_expire   = w_waiting & ~i_mem_rdata_valid & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        w_wr_addr  = w_waiting ? r_dest : (i_jal ? LINK_REG : i_dest);
        w_wr_data  = w_waiting ? w_aligned : (i_jal ? i_link_addr : i_alu_result);
        // $0 is never written, but a load to $0 still waits so memory ordering holds
        w_wr       = (w_done | (w_transfer & i_reg_write & (i_jal | ~i_mem_to_reg))) & (w_wr_addr != 5'd0);
        w_next     = w_load ? WAIT_MEM : ((w_done | w_expire) ? IDLE : r_state);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_dest    <= '0;
            r_type    <= '0;
            r_addr    <= '0;
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_wb_en   <= w_wr;
            r_timeout <= w_expire;
            if (w_load) begin
                r_cnt  <= '0;
                r_dest <= i_dest;
                r_type <= i_load_type;
                r_addr <= i_alu_result[1:0];
            end else if (w_waiting) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_wr) begin
                r_wb_addr <= w_wr_addr;
                r_wb_data <= w_wr_data;
            end
        end
    end

    assign o_ready        = (r_state == IDLE);
    assign o_stall        = ~o_ready;
    assign o_wb_en        = r_wb_en;
    assign o_wb_addr      = r_wb_addr;
    assign o_wb_data      = r_wb_data;
    assign o_load_timeout = r_timeout;
endmodule
